// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the PIPE power/detect controller.
package pipe_ctrl_pkg;

  // PIPE PowerDown encodings
  localparam logic [3:0] PD_P0  = 4'b0000;
  localparam logic [3:0] PD_P0S = 4'b0001;
  localparam logic [3:0] PD_P1  = 4'b0010;
  localparam logic [3:0] PD_P2  = 4'b0011;

  // RxStatus value reported for a detected receiver
  localparam logic [2:0] RXSTAT_DETECTED = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DET_WAIT = 3'd1,
    ST_DET_DONE = 3'd2,
    ST_PD_WAIT  = 3'd3,
    ST_PD_DONE  = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/pipe_lane_capture.sv
// Per-lane sticky PhyStatus capture with the receiver-detect result bit.
module pipe_lane_capture
  import pipe_ctrl_pkg::*;
(
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       result_clear,
  input  logic       capture_en,
  input  logic       result_en,
  input  logic       phy_status,
  input  logic [2:0] rx_status,
  output logic       captured,
  output logic       result
);

  // Sticky flag: set on first PhyStatus while a wait is active
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      captured <= 1'b0;
    end else if (clear) begin
      captured <= 1'b0;
    end else if (capture_en && phy_status) begin
      captured <= 1'b1;
    end
  end

  // Result sampled only on the first PhyStatus of a detect; repeats are ignored
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      result <= 1'b0;
    end else if (result_clear) begin
      result <= 1'b0;
    end else if (capture_en && result_en && phy_status && !captured) begin
      result <= (rx_status == RXSTAT_DETECTED);
    end
  end

endmodule

// File: rtl/pipe_power_detect_ctrl.sv
// MAC-side PIPE controller: sequences receiver detection and PowerDown
// changes across all lanes, waits on PhyStatus, and enforces a timeout.
module pipe_power_detect_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned PD_W           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  input  logic                   detect_req,
  input  logic                   pd_req,
  input  logic [PD_W-1:0]        pd_target,
  input  logic [NUM_LANES-1:0]   elec_idle_req,
  input  logic [NUM_LANES-1:0]   PhyStatus,
  input  logic [3*NUM_LANES-1:0] RxStatus,
  output logic                   TxDetectRx_Loopback,
  output logic [PD_W-1:0]        PowerDown,
  output logic [NUM_LANES-1:0]   TxElecIdle,
  output logic                   detect_done,
  output logic [NUM_LANES-1:0]   detect_result,
  output logic                   detect_timeout,
  output logic                   pd_ack,
  output logic                   busy
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_e          state_q;
  ctrl_state_e          state_d;
  logic [PD_W-1:0]      pd_d;
  logic [TMR_W-1:0]     timer_q;
  logic [NUM_LANES-1:0] mask;
  logic                 in_wait;
  logic                 in_det_wait;
  logic                 all_captured;
  logic                 expired;
  logic                 start;
  logic                 start_det;
  logic                 timeout_d;

  assign in_det_wait  = (state_q == ST_DET_WAIT);
  assign in_wait      = in_det_wait || (state_q == ST_PD_WAIT);
  assign all_captured = &(mask | PhyStatus);
  assign expired      = (timer_q == TMR_LAST);
  assign start        = (state_q == ST_IDLE) &&
                        ((state_d == ST_DET_WAIT) || (state_d == ST_PD_WAIT));
  assign start_det    = (state_q == ST_IDLE) && (state_d == ST_DET_WAIT);
  // Completion in the terminal timer cycle counts as success, not timeout
  assign timeout_d    = in_wait && expired && !all_captured;

  // Per-lane capture slices
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pipe_lane_capture u_cap (
      .pclk         (pclk),
      .reset_n      (reset_n),
      .clear        (start),
      .result_clear (start_det),
      .capture_en   (in_wait),
      .result_en    (in_det_wait),
      .phy_status   (PhyStatus[i]),
      .rx_status    (RxStatus[3*i +: 3]),
      .captured     (mask[i]),
      .result       (detect_result[i])
    );
  end

  // State register
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next PowerDown; detect wins over a simultaneous pd_req
  always_comb begin
    state_d = state_q;
    pd_d    = PowerDown;
    case (state_q)
      ST_IDLE: begin
        if (detect_req) begin
          state_d = ST_DET_WAIT;
          pd_d    = PD_W'(PD_P1);
        end else if (pd_req) begin
          if (pd_target != PowerDown) begin
            state_d = ST_PD_WAIT;
            pd_d    = pd_target;
          end else begin
            state_d = ST_PD_DONE;
          end
        end
      end
      ST_DET_WAIT: if (all_captured || expired) state_d = ST_DET_DONE;
      ST_PD_WAIT:  if (all_captured || expired) state_d = ST_PD_DONE;
      ST_DET_DONE: state_d = ST_IDLE;
      ST_PD_DONE:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Wait timer: cleared on entry, saturates at terminal count
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else if (start) begin
      timer_q <= '0;
    end else if (in_wait && !expired) begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  // Registered PHY-side and LTSSM-side outputs, driven from next-state values
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      TxDetectRx_Loopback <= 1'b0;
      PowerDown           <= PD_W'(PD_P1);
      TxElecIdle          <= {NUM_LANES{1'b1}};
      detect_done         <= 1'b0;
      detect_timeout      <= 1'b0;
      pd_ack              <= 1'b0;
      busy                <= 1'b0;
    end else begin
      TxDetectRx_Loopback <= (state_d == ST_DET_WAIT);
      PowerDown           <= pd_d;
      TxElecIdle          <= ((state_d == ST_DET_WAIT) || (pd_d != PD_W'(PD_P0))) ?
                             {NUM_LANES{1'b1}} : elec_idle_req;
      detect_done         <= (state_d == ST_DET_DONE);
      detect_timeout      <= timeout_d;
      pd_ack              <= (state_d == ST_PD_DONE);
      busy                <= (state_d != ST_IDLE);
    end
  end

endmodule
